// File: rtl/xor_dec_pkg.sv
// Shared constants, phase state type and key rotation helper for the XOR stream decryptor.
package xor_dec_pkg;

    localparam logic [7:0] KeyLoDefault = 8'hBE;
    localparam logic [7:0] KeyHiDefault = 8'hCA;
    localparam int unsigned FifoWidth   = 9;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;

    function automatic logic [15:0] rotl16(input logic [15:0] v);
        return {v[14:0], v[15]};
    endfunction

endpackage

// File: rtl/xor_dec_fifo2.sv
// Two-entry valid/ready FIFO. Occupancy is registered, so ready_o never depends on ready_i.
module xor_dec_fifo2 #(
    parameter int unsigned Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign ready_o = (count_q < 2'd2);
    assign valid_o = (count_q != 2'd0);
    // Empty FIFO presents zero rather than a stale entry.
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/xor_stream_decrypt.sv
// Byte-wise XOR stream decryptor alternating two key bytes, with a 2-entry output FIFO.
// Define XOR_DEC_ROLL_EN to rotate the 16-bit key after every high-phase byte.
module xor_stream_decrypt
    import xor_dec_pkg::*;
#(
    parameter logic [7:0] KEY_LO = KeyLoDefault,
    parameter logic [7:0] KEY_HI = KeyHiDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_sync,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_phase,
    output logic [7:0] byte_count
);

    phase_e         state_q, state_d;
    phase_e         phase_use;
    logic [7:0]     count_q, count_d;
    logic           in_xfer;
    logic [7:0]     key_lo_cur, key_hi_cur;
    logic [7:0]     plain;
    logic [FifoWidth-1:0] fifo_out;

    assign in_xfer    = in_valid && in_ready;
    // A sync byte always starts a frame on the low key.
    assign phase_use  = in_sync ? PH_LO : state_q;
    assign plain      = in_data ^ ((phase_use == PH_HI) ? key_hi_cur : key_lo_cur);
    assign byte_count = count_q;

`ifdef XOR_DEC_ROLL_EN
    logic [15:0] key_q, key_d;

    assign key_lo_cur = in_sync ? KEY_LO : key_q[7:0];
    assign key_hi_cur = key_q[15:8];

    always_comb begin
        key_d = key_q;
        if (in_xfer) begin
            if (in_sync) begin
                key_d = {KEY_HI, KEY_LO};
            end else if (state_q == PH_HI) begin
                key_d = rotl16(key_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= {KEY_HI, KEY_LO};
        end else begin
            key_q <= key_d;
        end
    end
`else
    assign key_lo_cur = KEY_LO;
    assign key_hi_cur = KEY_HI;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (in_xfer) begin
            if (in_sync) begin
                state_d = PH_HI;
                count_d = 8'd1;
            end else begin
                state_d = (state_q == PH_LO) ? PH_HI : PH_LO;
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PH_LO;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    xor_dec_fifo2 #(
        .Width (FifoWidth)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (in_valid),
        .ready_o (in_ready),
        .data_i  ({phase_use == PH_HI, plain}),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .data_o  (fifo_out)
    );

    assign out_phase = fifo_out[8];
    assign out_data  = fifo_out[7:0];

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Directed self-checking bench for xor_stream_decrypt (default keys BE/CA).
module tb_xor_stream_decrypt;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_sync;
    logic [7:0] in_data;
    logic       out_valid, out_ready, out_phase;
    logic [7:0] out_data, byte_count;

    int n_cmp = 0;
    int n_err = 0;

`ifdef XOR_DEC_ROLL_EN
    localparam logic [7:0] ThirdFf  = 8'h82;
    localparam logic [7:0] Third33  = 8'h4E;
`else
    localparam logic [7:0] ThirdFf  = 8'h41;
    localparam logic [7:0] Third33  = 8'h8D;
`endif

    xor_stream_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sync    (in_sync),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_phase  (out_phase),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic ph);
        check_eq({tag, ".valid"}, 16'(out_valid), 16'h1);
        check_eq({tag, ".data"},  16'(out_data),  16'(d));
        check_eq({tag, ".phase"}, 16'(out_phase), 16'(ph));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #1;
        check_eq("rst.valid", 16'(out_valid), 16'h0);
        check_eq("rst.data",  16'(out_data),  16'h0);
        check_eq("rst.phase", 16'(out_phase), 16'h0);
        check_eq("rst.count", 16'(byte_count), 16'h0);
        check_eq("rst.ready", 16'(in_ready),  16'h1);

        // Single byte, one-cycle latency.
        do_reset();
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        check_out("single", 8'h41, 1'b0);
        check_eq("single.count", 16'(byte_count), 16'd1);
        out_ready = 1'b1;
        tick();
        check_eq("single.drain", 16'(out_valid), 16'h0);

        // Back-to-back with consumer ready.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        check_out("b2b0", 8'h41, 1'b0);
        tick();
        in_valid = 1'b0;
        check_out("b2b1", 8'h35, 1'b1);
        check_eq("b2b.count", 16'(byte_count), 16'd2);
        tick();
        check_eq("b2b.drain", 16'(out_valid), 16'h0);

        // Backpressure: third byte held, all delivered in order.
        do_reset();
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        check_eq("bp.ready1", 16'(in_ready), 16'h1);
        in_data = 8'h22;
        tick();
        check_eq("bp.ready2", 16'(in_ready), 16'h0);
        in_data = 8'h33;
        tick();
        check_eq("bp.held.count", 16'(byte_count), 16'd2);
        check_out("bp.head", 8'hAF, 1'b0);
        out_ready = 1'b1;
        tick();
        check_out("bp.o2", 8'hE8, 1'b1);
        tick();
        in_valid = 1'b0;
        check_out("bp.o3", Third33, 1'b0);
        check_eq("bp.count", 16'(byte_count), 16'd3);
        tick();
        check_eq("bp.drain", 16'(out_valid), 16'h0);

        // Sync without valid is ignored; sync in PH_HI restarts on low key.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_valid = 1'b0; in_sync = 1'b1;
        tick();
        check_eq("nosync.count", 16'(byte_count), 16'd1);
        in_valid = 1'b1;
        tick();
        in_sync = 1'b0;
        check_out("sync", 8'h41, 1'b0);
        check_eq("sync.count", 16'(byte_count), 16'd1);
        tick();
        in_valid = 1'b0;
        check_out("sync.next", 8'h35, 1'b1);
        check_eq("sync.next.count", 16'(byte_count), 16'd2);

        // Three bytes: third depends on key rolling.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        check_out("roll0", 8'h41, 1'b0);
        tick();
        check_out("roll1", 8'h35, 1'b1);
        tick();
        in_valid = 1'b0;
        check_out("roll2", ThirdFf, 1'b0);

        // byte_count wraps 255 -> 0.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h00;
        for (int i = 0; i < 255; i++) tick();
        check_eq("wrap.255", 16'(byte_count), 16'd255);
        tick();
        in_valid = 1'b0;
        check_eq("wrap.0", 16'(byte_count), 16'd0);

        // Asynchronous reset with a full FIFO.
        do_reset();
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        tick();
        in_valid = 1'b0;
        check_eq("full.ready", 16'(in_ready), 16'h0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst.valid", 16'(out_valid), 16'h0);
        check_eq("arst.count", 16'(byte_count), 16'h0);
        check_eq("arst.ready", 16'(in_ready), 16'h1);
        check_eq("arst.data",  16'(out_data), 16'h0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        check_out("post", 8'h41, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xor_stream_decrypt.md
XOR_STREAM_DECRYPT -- requirements
Module: xor_stream_decrypt

Interface
REQ-001 Parameter KEY_LO, default 8'hBE, low key byte (even stream positions).
REQ-002 Parameter KEY_HI, default 8'hCA, high key byte (odd stream positions).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  ciphertext byte present on in_data.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 in_data  input  8  ciphertext byte.
REQ-008 in_sync  input  1  frame start; qualified by in_valid && in_ready.
REQ-009 out_valid  output  1  plaintext byte present on out_data.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_data  output  8  plaintext byte.
REQ-012 out_phase  output  1  key byte used for out_data (0=LO, 1=HI).
REQ-013 byte_count  output  8  accepted input bytes since reset or last sync, modulo 256.

Function
REQ-014 Input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
REQ-015 Plaintext = in_data XOR current key byte, computed at input transfer; stored with its phase bit in a 2-entry FIFO.
REQ-016 Phase FSM states PH_LO, PH_HI: each input transfer toggles the state; transfer with in_sync uses KEY_LO and leaves the FSM in PH_HI.
REQ-017 in_ready = FIFO occupancy < 2 (registered occupancy, no combinational path from out_ready).
REQ-018 out_valid = occupancy > 0; out_data/out_phase = FIFO head; head held stable while out_valid && !out_ready.
REQ-019 Latency: byte accepted at edge N appears on out_data after edge N (visible in cycle N+1) when FIFO was empty.
REQ-020 Simultaneous push and pop at occupancy 1: occupancy stays 1, order preserved; at occupancy 2 push impossible, pop lowers to 1.
REQ-021 byte_count increments by 1 per input transfer, wraps 255->0; transfer with in_sync sets it to 1.
REQ-022 No input transfer when in_valid low; in_sync ignored without transfer.

Reset
REQ-023 rst asserted: occupancy 0, FSM PH_LO, byte_count 0, key register = {KEY_HI,KEY_LO}, immediately (asynchronous).
REQ-024 Outputs during/after reset: out_valid 0, out_data 8'h00, out_phase 0, in_ready 1 one cycle after rst deasserts is not required -- in_ready 1 as soon as occupancy reads 0.
REQ-025 Reset mid-stream discards FIFO contents; first byte after reset uses KEY_LO.

Configuration
REQ-026 Macro XOR_DEC_ROLL_EN defined: after each input transfer in PH_HI, 16-bit key register {HI,LO} rotates left by 1; transfer with in_sync reloads {KEY_HI,KEY_LO} before use.
REQ-027 Macro XOR_DEC_ROLL_EN undefined: key fixed at KEY_LO/KEY_HI; no rotation logic synthesised.

Structure
REQ-028 Package xor_dec_pkg holds default key constants and phase state typedef (PH_LO, PH_HI).
REQ-029 FIFO is sub-module xor_dec_fifo2 (2 entries x 9 bits, valid/ready both sides).

Verification
REQ-030 Reset, in_data 8'hFF valid one cycle -> next cycle out_valid 1, out_data 8'h41, out_phase 0, byte_count 1.
REQ-031 Two bytes 8'hFF, 8'hFF back-to-back, out_ready 1 -> out_data 8'h41 then 8'h35, phases 0 then 1.
REQ-032 out_ready 0, push 3 bytes -> in_ready drops after 2nd accept; 3rd held; release out_ready -> all 3 delivered in order, none lost.
REQ-033 Mid-stream in_sync on byte in PH_HI with data 8'hFF -> out_data 8'h41, phase 0, byte_count 1.
REQ-034 XOR_DEC_ROLL_EN defined, three bytes 8'hFF -> 8'h41, 8'h35, 8'h82 (key 16'h957D after rotation).
REQ-035 rst asserted while FIFO holds 2 bytes -> out_valid 0 immediately, byte_count 0; next byte decrypted with KEY_LO.
